// File: rtl/axi_copy_dma_if.sv
// AXI4 bus bundle between the copy DMA (master) and a memory slave.
// Address/data/id widths are parameters; the DMA assumes 32-bit address and data.
interface axi_ifc #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
);
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_copy_dma.sv
// Single-channel AXI copy engine: INCR read burst into a local buffer, then an
// INCR write burst out of it, repeated until the word count is used up.
module axi_copy_dma #(
  parameter int BURST_MAX = 16,
  parameter int ID        = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  axi_ifc.master      m
);
  localparam int IW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;
  state_t state, state_nxt;

  logic [31:0] src, dst, src_n, dst_n, id_w;
  logic [15:0] remaining, rem_n;
  logic [8:0]  len, len_c, beat, idx, idx_inc;
  logic [16:0] lim, wl_src, wl_dst;
  logic [31:0] bmem [2**IW];
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, unused_ok;

  assign ar_hs   = m.arvalid & m.arready;
  assign r_hs    = m.rvalid  & m.rready;
  assign aw_hs   = m.awvalid & m.awready;
  assign w_hs    = m.wvalid  & m.wready;
  assign b_hs    = m.bvalid  & m.bready;
  assign idx_inc = idx + 9'd1;
  assign id_w    = ID;

  assign m.arid    = id_w[$bits(m.arid)-1:0];
  assign m.araddr  = src;
  assign m.arlen   = 8'(len - 9'd1);
  assign m.arsize  = 3'd2;
  assign m.arburst = 2'b01;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.awid    = id_w[$bits(m.awid)-1:0];
  assign m.awaddr  = dst;
  assign m.awlen   = 8'(len - 9'd1);
  assign m.awsize  = 3'd2;
  assign m.awburst = 2'b01;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.wstrb   = '1;
  assign unused_ok = ^{src_addr[1:0], dst_addr[1:0], m.rid, m.bid, lim[16:9], id_w};

  // Next-burst pointers: fresh from the ports in IDLE, advanced by len after a burst.
  always_comb begin
    src_n  = (state == IDLE) ? {src_addr[31:2], 2'b00} : src + {21'd0, len, 2'b00};
    dst_n  = (state == IDLE) ? {dst_addr[31:2], 2'b00} : dst + {21'd0, len, 2'b00};
    rem_n  = (state == IDLE) ? word_count : remaining - {7'd0, len};
    wl_src = 17'd1024 - {7'd0, src_n[11:2]};
    wl_dst = 17'd1024 - {7'd0, dst_n[11:2]};
    lim    = {1'b0, rem_n};
    if (17'(BURST_MAX) < lim) lim = 17'(BURST_MAX);
    if (wl_src < lim) lim = wl_src;
    if (wl_dst < lim) lim = wl_dst;
    len_c  = lim[8:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && word_count != 16'd0) state_nxt = RADDR;
      RADDR:   if (ar_hs) state_nxt = RDATA;
      RDATA:   if (r_hs && m.rlast) state_nxt = WADDR;
      WADDR:   if (aw_hs) state_nxt = WDATA;
      WDATA:   if (w_hs && m.wlast) state_nxt = WRESP;
      WRESP:   if (b_hs) state_nxt = (remaining == {7'd0, len}) ? IDLE : RADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src <= '0; dst <= '0; remaining <= '0; len <= '0; beat <= '0; idx <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0;
      m.arvalid <= 1'b0; m.rready <= 1'b0; m.awvalid <= 1'b0; m.bready <= 1'b0;
      m.wvalid <= 1'b0; m.wlast <= 1'b0; m.wdata <= '0;
    end else begin
      done      <= 1'b0;
      m.arvalid <= (state_nxt == RADDR);
      m.rready  <= (state_nxt == RDATA);
      m.awvalid <= (state_nxt == WADDR);
      m.bready  <= (state_nxt == WRESP);
      if ((state == IDLE && start) || b_hs) begin
        src <= src_n; dst <= dst_n; remaining <= rem_n;
      end
      if (state_nxt == RADDR && state != RADDR) len <= len_c;
      if (state == IDLE && start) begin
        err  <= 1'b0;
        busy <= (word_count != 16'd0);
        done <= (word_count == 16'd0);
      end
      if (b_hs && state_nxt == IDLE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (ar_hs) beat <= '0;
      if (r_hs) begin
        if (m.rresp != 2'b00 || (m.rlast && beat != len - 9'd1)) err <= 1'b1;
        if (beat != '1) beat <= beat + 9'd1;
      end
      if (b_hs && m.bresp != 2'b00) err <= 1'b1;
      // Write beat pipeline: wdata is preloaded from the buffer one handshake ahead.
      if (aw_hs) begin
        m.wvalid <= 1'b1;
        m.wlast  <= (len == 9'd1);
        m.wdata  <= bmem[0];
        idx      <= '0;
      end else if (w_hs) begin
        if (m.wlast) begin
          m.wvalid <= 1'b0;
          m.wlast  <= 1'b0;
        end else begin
          idx     <= idx_inc;
          m.wdata <= bmem[idx_inc[IW-1:0]];
          m.wlast <= (idx_inc == len - 9'd1);
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (r_hs && beat < 9'(BURST_MAX)) bmem[beat[IW-1:0]] <= m.rdata;

endmodule

// File: tb/tb_axi_copy_dma.sv
// Directed bench for axi_copy_dma against a behavioural AXI memory slave with
// optional random handshake stalls and an injectable bresp error.
module tb_axi_copy_dma;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, err;
  int          n_cmp = 0, n_bad = 0;

  axi_ifc bus();

  axi_copy_dma #(.BURST_MAX(16), .ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy), .done(done), .err(err), .m(bus.master)
  );

  always #5 clk = ~clk;

  // Slave: reads come from src_mem, writes land in dst_mem.
  logic [31:0] src_mem [4096];
  logic [31:0] dst_mem [4096];
  bit          stall_en = 1'b0;
  int          force_b = -1, b_num = 0;
  logic        rd_act, wr_act, b_pend, ar_g, r_g, aw_g, w_g, b_g;
  logic [11:0] rd_ptr, wr_ptr;
  logic [8:0]  rd_left;

  assign bus.arready = ar_g && !rd_act;
  assign bus.rvalid  = rd_act && r_g;
  assign bus.rdata   = src_mem[rd_ptr];
  assign bus.rlast   = (rd_left == 9'd1);
  assign bus.rresp   = 2'b00;
  assign bus.rid     = '0;
  assign bus.awready = aw_g && !wr_act && !b_pend;
  assign bus.wready  = wr_act && w_g;
  assign bus.bvalid  = b_pend && b_g;
  assign bus.bresp   = (b_num == force_b) ? 2'd2 : 2'd0;
  assign bus.bid     = '0;

  function automatic bit rnd();
    return stall_en ? ($urandom_range(1, 0) == 1) : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_act <= 0; wr_act <= 0; b_pend <= 0; rd_ptr <= 0; wr_ptr <= 0; rd_left <= 0;
      ar_g <= 0; r_g <= 0; aw_g <= 0; w_g <= 0; b_g <= 0;
    end else begin
      ar_g <= rnd(); aw_g <= rnd(); w_g <= rnd();
      r_g  <= (bus.rvalid && !bus.rready) ? 1'b1 : rnd();
      b_g  <= (bus.bvalid && !bus.bready) ? 1'b1 : rnd();
      if (bus.arvalid && bus.arready) begin
        rd_act <= 1; rd_ptr <= bus.araddr[13:2]; rd_left <= {1'b0, bus.arlen} + 9'd1;
      end
      if (bus.rvalid && bus.rready) begin
        rd_ptr <= rd_ptr + 12'd1; rd_left <= rd_left - 9'd1;
        if (rd_left == 9'd1) rd_act <= 0;
      end
      if (bus.awvalid && bus.awready) begin
        wr_act <= 1; wr_ptr <= bus.awaddr[13:2];
      end
      if (bus.wvalid && bus.wready) begin
        dst_mem[wr_ptr] <= bus.wdata; wr_ptr <= wr_ptr + 12'd1;
        if (bus.wlast) begin wr_act <= 0; b_pend <= 1; end
      end
      if (bus.bvalid && bus.bready) begin b_pend <= 0; b_num <= b_num + 1; end
    end

  // Transaction log and protocol monitor (valid must hold with stable payload).
  int          ar_n = 0, aw_n = 0, done_n = 0, viol = 0;
  logic [31:0] ar_addr_log [64], aw_addr_log [64];
  logic [7:0]  ar_len_log [64], aw_len_log [64];
  logic        p_ar = 0, p_aw = 0, p_w = 0, p_wlast = 0;
  logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0;
  logic [7:0]  p_arlen = 0, p_awlen = 0;

  always @(posedge clk) begin
    if (done === 1'b1) done_n <= done_n + 1;
    if (bus.arvalid && bus.arready) begin
      ar_addr_log[ar_n[5:0]] <= bus.araddr; ar_len_log[ar_n[5:0]] <= bus.arlen; ar_n <= ar_n + 1;
    end
    if (bus.awvalid && bus.awready) begin
      aw_addr_log[aw_n[5:0]] <= bus.awaddr; aw_len_log[aw_n[5:0]] <= bus.awlen; aw_n <= aw_n + 1;
    end
    if (rst_n && ((bus.awvalid && bus.awready && rd_act) ||
        (p_ar && (!bus.arvalid || bus.araddr != p_araddr || bus.arlen != p_arlen)) ||
        (p_aw && (!bus.awvalid || bus.awaddr != p_awaddr || bus.awlen != p_awlen)) ||
        (p_w  && (!bus.wvalid || bus.wdata != p_wdata || bus.wlast != p_wlast))))
      viol <= viol + 1;
    p_ar <= rst_n && bus.arvalid && !bus.arready;
    p_aw <= rst_n && bus.awvalid && !bus.awready;
    p_w  <= rst_n && bus.wvalid && !bus.wready;
    p_araddr <= bus.araddr; p_arlen <= bus.arlen;
    p_awaddr <= bus.awaddr; p_awlen <= bus.awlen;
    p_wdata  <= bus.wdata;  p_wlast <= bus.wlast;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_words(input string tag, input int dw, input int sw, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (dst_mem[dw+i] !== src_mem[sw+i]) bad++;
    chk(tag, bad, 0);
  endtask

  int a0, w0, d0, k;

  initial begin
    for (int i = 0; i < 4096; i++) src_mem[i] = 32'hC0DE_0000 + i;
    for (int i = 0; i < 40; i++) src_mem[i] = i;
    src_mem[64] = 32'hDEADBEEF;

    #1 rst_n = 1'b0;
    #1 chk("reset_outs", {busy, done, err, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                          bus.wlast, bus.bready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word
    a0 = ar_n; w0 = aw_n; d0 = done_n;
    start_copy(32'h100, 32'h200, 16'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1_done");
    chk("t1_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_ar_cnt", ar_n - a0, 1);
    chk("t1_araddr", ar_addr_log[a0], 32'h100);
    chk("t1_arlen", {24'd0, ar_len_log[a0]}, 32'd0);
    chk("t1_awaddr", aw_addr_log[w0], 32'h200);
    chk("t1_awlen", {24'd0, aw_len_log[w0]}, 32'd0);
    chk("t1_data", dst_mem[128], 32'hDEADBEEF);
    chk("t1_done_cnt", done_n - d0, 1);
    chk("t1_busy_off", {31'd0, busy}, 32'd0);

    // Multi-burst, with a start pulse during the copy that must be ignored
    a0 = ar_n; w0 = aw_n; d0 = done_n;
    start_copy(32'h0, 32'h1000, 16'd40);
    k = 0;
    while (!bus.rready && k < 100) begin @(negedge clk); k++; end
    chk("t2_in_rdata", {31'd0, bus.rready}, 32'd1);
    src_addr = 32'h100; dst_addr = 32'h3F00; word_count = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2_done");
    repeat (2) @(negedge clk);
    chk("t2_ar_cnt", ar_n - a0, 3);
    chk("t2_arlen0", {24'd0, ar_len_log[a0]}, 32'd15);
    chk("t2_arlen1", {24'd0, ar_len_log[a0+1]}, 32'd15);
    chk("t2_arlen2", {24'd0, ar_len_log[a0+2]}, 32'd7);
    chk("t2_araddr2", ar_addr_log[a0+2], 32'h80);
    chk("t2_awaddr1", aw_addr_log[w0+1], 32'h1040);
    chk("t2_word0", dst_mem[1024], 32'd0);
    chk("t2_word39", dst_mem[1063], 32'd39);
    chk_words("t2_words", 1024, 0, 40);
    chk("t2_done_cnt", done_n - d0, 1);

    // 4 KB split on the source side
    a0 = ar_n; w0 = aw_n;
    start_copy(32'h0FF8, 32'h2000, 16'd4);
    wait_done("t3_done");
    repeat (2) @(negedge clk);
    chk("t3_ar_cnt", ar_n - a0, 2);
    chk("t3_arlen0", {24'd0, ar_len_log[a0]}, 32'd1);
    chk("t3_araddr1", ar_addr_log[a0+1], 32'h1000);
    chk("t3_arlen1", {24'd0, ar_len_log[a0+1]}, 32'd1);
    chk("t3_awaddr1", aw_addr_log[w0+1], 32'h2008);
    chk("t3_word0", dst_mem[2048], 32'hC0DE_03FE);
    chk("t3_word3", dst_mem[2051], 32'hC0DE_0401);

    // Zero count
    a0 = ar_n; d0 = done_n;
    start_copy(32'h0, 32'h0, 16'd0);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t4_no_ar", ar_n - a0, 0);
    chk("t4_done_once", done_n - d0, 1);
    chk("t4_arvalid", {31'd0, bus.arvalid}, 32'd0);

    // Random backpressure
    stall_en = 1'b1;
    a0 = ar_n;
    start_copy(32'h300, 32'h2400, 16'd20);
    wait_done("t5_done");
    repeat (2) @(negedge clk);
    chk("t5_ar_cnt", ar_n - a0, 2);
    chk("t5_arlen1", {24'd0, ar_len_log[a0+1]}, 32'd3);
    chk_words("t5_words", 2304, 192, 20);
    chk("t5_word19", dst_mem[2323], 32'hC0DE_00D3);
    chk("t5_protocol", viol, 0);

    // bresp error is sticky until the next start
    force_b = b_num;
    start_copy(32'h0, 32'h2800, 16'd3);
    wait_done("t6_done");
    chk("t6_err_set", {31'd0, err}, 32'd1);
    force_b = -1;
    start_copy(32'h100, 32'h2C00, 16'd1);
    chk("t6_err_clear", {31'd0, err}, 32'd0);
    wait_done("t6b_done");
    chk("t6b_err", {31'd0, err}, 32'd0);
    chk("t6b_data", dst_mem[2816], 32'hDEADBEEF);
    stall_en = 1'b0;

    // Asynchronous reset in the middle of the read burst
    start_copy(32'h0, 32'h3000, 16'd20);
    k = 0;
    while (!bus.rready && k < 100) begin @(negedge clk); k++; end
    chk("t7_in_rdata", {31'd0, bus.rready}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t7_reset_outs", {busy, done, err, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                             bus.wlast, bus.bready}, 32'd0);
    chk("t7_state", {29'd0, dut.state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_copy(32'h40, 32'h3800, 16'd3);
    wait_done("t7_done");
    chk("t7_word0", dst_mem[3584], 32'd16);
    chk("t7_word2", dst_mem[3586], 32'd18);
    chk("t7_err", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_copy_dma.md
Name: axi_copy_dma

Overview:
- Single-channel AXI master DMA engine. Copies a block of 32-bit words from a source address to a destination address.
- Copies in bursts: an INCR read burst fills an internal burst buffer, then a matching INCR write burst drains it. Repeats until the word count is exhausted.
- Sits directly upstream of the AXI SRAM slave and drives its AXI slave port. It is the block used to fill, move and scrub SRAM contents from a simple start/done control interface.

Parameters:
BURST_MAX, 16, maximum beats per burst (1..256); sets the burst buffer depth.
ID, 0, value driven on arid and awid for every transaction.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a copy; sampled only when busy=0.
src_addr  input  32  source byte address; bits [1:0] are ignored (treated as 0).
dst_addr  input  32  destination byte address; bits [1:0] are ignored.
word_count  input  16  number of 32-bit words to copy; 0 is legal.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when the copy completes.
err  output  1  sticky flag: a nonzero rresp/bresp or a misplaced rlast occurred during the current copy; cleared on the next accepted start.
m  axi_ifc.master  -  AXI master port; widths are inherited from the interface; data width is 32.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, arvalid, rready, awvalid, wvalid, wlast, bready all 0; internal address and count registers 0.
- All AXI outputs are registered. A valid, once raised, holds with stable payload until its handshake completes.
- Fixed AXI fields on every transaction:
  - arsize=awsize=2; arburst=awburst=INCR; wstrb all ones.
  - arid=awid=ID; unused cache/prot/lock fields are 0.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE:
  - start=1 latches src, dst and remaining=word_count, and clears err.
  - If word_count=0: done pulses the next cycle, busy stays 0, no AXI traffic.
  - Otherwise: busy=1 and the next state is RADDR.
  - start while busy=1 is ignored.
- Burst length len:
  - len = min(remaining, BURST_MAX, words left to the next 4 KB boundary of src, words left to the next 4 KB boundary of dst).
  - len is computed on entry to RADDR and held constant through WRESP.
  - arlen=awlen=len-1.
- RADDR: arvalid=1 with araddr=src; on arready goes to RDATA.
- RDATA:
  - rready=1. Each rvalid&rready beat writes rdata to buf[beat] and increments beat.
  - rresp!=0 sets err.
  - If rlast arrives on a beat other than len-1, err is set.
  - The state exits on the rlast beat; an rlast arriving after beat len-1 without wlast semantics is still honoured.
  - Beats beyond BURST_MAX are dropped.
- WADDR: awvalid=1 with awaddr=dst; on awready goes to WDATA. The write address is not issued before the read burst has completed.
- WDATA:
  - wvalid=1 with wdata=buf[idx] and wlast=(idx==len-1).
  - idx advances on each wready handshake.
  - After the wlast handshake, wvalid drops and the state goes to WRESP.
- WRESP:
  - bready=1. On bvalid: bresp!=0 sets err; src+=4*len; dst+=4*len; remaining-=len.
  - If remaining=0: state=IDLE, busy=0, done=1 for one cycle. Otherwise state=RADDR.
- Address arithmetic is modulo 2^32; no burst ever crosses a 4 KB boundary.
- Overlapping regions are copied in ascending order with no hazard protection. For dst>src with overlap, results are defined only as per-burst buffered copies.
- Reset asserted mid-copy aborts immediately to the reset values. An outstanding AXI transaction is abandoned; the slave must also be reset.
- Throughput: at most one beat per cycle in each of RDATA and WDATA; no read/write overlap.

Test Plan:
- Single word: preload SRAM[0x100]=0xDEADBEEF; start src=0x100 dst=0x200 count=1 → one AR (arlen=0) and one AW (awlen=0); SRAM[0x200]=0xDEADBEEF; done pulses once; err=0.
- Multi-burst: count=40, BURST_MAX=16, src=0x0, dst=0x1000, SRAM[i]=i → bursts of 16, 16 and 8 (arlen 15, 15, 7); dst words 0..39 match; one done pulse.
- 4 KB split: src=0x0FF8, dst=0x2000, count=4 → first burst len=2 (arlen=1), second len=2 at src=0x1000, dst=0x2008; data correct.
- Zero count and busy start: count=0 → done at the next cycle, no arvalid. start pulsed during an active copy → ignored; the copy completes unchanged.
- Backpressure and errors: a slave model with random awready/wready/rvalid stalls → all data correct and no valid drops before its handshake. Force bresp=2 on one burst → err=1 at done; err clears on the next start.
- Reset mid-RDATA: drop rst_n asynchronously → all outputs 0 within the same cycle, state IDLE; a new copy after release completes correctly.
